// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: line count, FSM encoding
// and the one-hot helper used for acknowledge/clear masks.
package irq_ctrl_pkg;

    localparam int NIRQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    function automatic logic [NIRQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc4.sv
// Fixed-priority encoder: reports the index of the lowest set request bit.
module prio_enc4 (
    input  logic [3:0] req,
    output logic [1:0] idx,
    output logic       valid
);

    // Lowest index wins; valid drops when nothing is requested
    always_comb begin
        idx   = 2'd0;
        valid = 1'b1;
        casez (req)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: begin
                idx   = 2'd0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/irq_ctrl.sv
// Four-line edge-triggered interrupt controller with fixed priority,
// an enable mask and non-nesting IDLE/TAKE/SERVICE sequencing.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [9:0] VEC_BASE = 10'h3F0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  irq,
    input  logic        ie_we,
    input  logic [3:0]  ie_wd,
    input  logic        take_ok,
    input  logic        reti,
    output logic        int_take,
    output logic [9:0]  int_vec,
    output logic [3:0]  irq_ack,
    output logic        in_isr,
    output logic [3:0]  pend
);

    irq_state_e      state_r;
    irq_state_e      state_nxt_s;
    logic [NIRQ-1:0] irq_d_r;
    logic [NIRQ-1:0] pend_r;
    logic [NIRQ-1:0] ie_r;
    logic [1:0]      cur_r;
    logic [NIRQ-1:0] new_s;
    logic [NIRQ-1:0] clr_s;
    logic [NIRQ-1:0] elig_s;
    logic [1:0]      enc_idx_s;
    logic            enc_valid_s;
    logic            int_take_r;
    logic [3:0]      irq_ack_r;
    logic            in_isr_r;
    logic [9:0]      int_vec_r;

    assign new_s  = irq & ~irq_d_r;
    assign elig_s = pend_r & ie_r;

    prio_enc4 u_prio (
        .req   (elig_s),
        .idx   (enc_idx_s),
        .valid (enc_valid_s)
    );

    // Next-state decode; the taken line is cleared as the block leaves TAKE
    always_comb begin
        state_nxt_s = state_r;
        clr_s       = '0;
        case (state_r)
            ST_IDLE: begin
                if (enc_valid_s && take_ok) begin
                    state_nxt_s = ST_TAKE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TAKE: begin
                clr_s       = onehot4(cur_r);
                state_nxt_s = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (reti) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, request tracking and registered outputs (computed from next state
    // so they line up with the cycle the FSM sits in TAKE/SERVICE)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            irq_d_r    <= '0;
            pend_r     <= '0;
            ie_r       <= '0;
            cur_r      <= 2'd0;
            int_take_r <= 1'b0;
            irq_ack_r  <= '0;
            in_isr_r   <= 1'b0;
            int_vec_r  <= VEC_BASE;
        end else begin
            state_r <= state_nxt_s;
            irq_d_r <= irq;
            pend_r  <= (pend_r & ~clr_s) | new_s;
            if (ie_we) begin
                ie_r <= ie_wd;
            end
            if (state_nxt_s == ST_TAKE) begin
                cur_r      <= enc_idx_s;
                int_vec_r  <= VEC_BASE + {6'd0, enc_idx_s, 2'd0};
                int_take_r <= 1'b1;
                irq_ack_r  <= onehot4(enc_idx_s);
            end else begin
                int_take_r <= 1'b0;
                irq_ack_r  <= '0;
            end
            in_isr_r <= (state_nxt_s == ST_SERVICE);
        end
    end

    assign int_take = int_take_r;
    assign irq_ack  = irq_ack_r;
    assign in_isr   = in_isr_r;
    assign int_vec  = int_vec_r;
    assign pend     = pend_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       ie_we;
    logic [3:0] ie_wd;
    logic       take_ok;
    logic       reti;
    logic       int_take;
    logic [9:0] int_vec;
    logic [3:0] irq_ack;
    logic       in_isr;
    logic [3:0] pend;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    irq_ctrl #(.VEC_BASE(10'h3F0)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .ie_we    (ie_we),
        .ie_wd    (ie_wd),
        .take_ok  (take_ok),
        .reti     (reti),
        .int_take (int_take),
        .int_vec  (int_vec),
        .irq_ack  (irq_ack),
        .in_isr   (in_isr),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase 0 = waiting, 1 = vectoring, 2 = in handler
    bit [3:0] m_pend, m_ie, m_prev;
    int       m_phase, m_cur, m_found;
    bit [9:0] m_vec;

    always @(posedge clk) begin
        if (reset) begin
            m_pend = 4'd0; m_ie = 4'd0; m_prev = 4'd0;
            m_phase = 0; m_cur = 0; m_vec = 10'h3F0;
        end else begin
            m_found = -1;
            for (int i = 3; i >= 0; i--)
                if (m_pend[i] && m_ie[i]) m_found = i;
            case (m_phase)
                0: if (m_found >= 0 && take_ok) begin
                       m_phase = 1;
                       m_cur   = m_found;
                       m_vec   = 10'((32'h3F0 + 4 * m_found) % 1024);
                   end
                1: begin m_pend[m_cur] = 1'b0; m_phase = 2; end
                2: if (reti) m_phase = 0;
                default: m_phase = 0;
            endcase
            m_pend = m_pend | (irq & ~m_prev);
            if (ie_we) m_ie = ie_wd;
            m_prev = irq;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_int_take", 32'(int_take), 32'(m_phase == 1));
            chk("m_irq_ack",  32'(irq_ack),  (m_phase == 1) ? (32'd1 << m_cur) : 32'd0);
            chk("m_in_isr",   32'(in_isr),   32'(m_phase == 2));
            chk("m_int_vec",  32'(int_vec),  32'(m_vec));
            chk("m_pend",     32'(pend),     32'(m_pend));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic ret_pulse();
        reti = 1'b1; cyc(); reti = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq = 4'd0; ie_we = 1'b0; ie_wd = 4'd0;
        take_ok = 1'b1; reti = 1'b0;
        cyc(2);
        chk_en = 1'b1;
        chk("rst_pend", 32'(pend), 32'h0);
        chk("rst_in_isr", 32'(in_isr), 32'h0);
        chk("rst_int_take", 32'(int_take), 32'h0);
        chk("rst_int_vec", 32'(int_vec), 32'h3F0);
        reset = 1'b0;

        // Single request on line 2
        ie_we = 1'b1; ie_wd = 4'b0100; cyc(); ie_we = 1'b0;
        irq = 4'b0100; cyc();
        chk("s1_pend", 32'(pend), 32'h4);
        chk("s1_no_take", 32'(int_take), 32'h0);
        cyc();
        chk("s1_take", 32'(int_take), 32'h1);
        chk("s1_vec", 32'(int_vec), 32'h3F8);
        chk("s1_ack", 32'(irq_ack), 32'h4);
        cyc();
        chk("s1_isr", 32'(in_isr), 32'h1);
        chk("s1_take_end", 32'(int_take), 32'h0);
        cyc(3);
        chk("s1_isr_hold", 32'(in_isr), 32'h1);
        chk("s1_vec_hold", 32'(int_vec), 32'h3F8);
        ret_pulse();
        chk("s1_isr_off", 32'(in_isr), 32'h0);
        cyc(2);
        chk("s1_level_once", 32'(int_take), 32'h0);
        irq = 4'd0; cyc();

        // Simultaneous lines 3 and 1, then line 0 arriving during service
        ie_we = 1'b1; ie_wd = 4'hF; cyc(); ie_we = 1'b0;
        irq = 4'b1010; cyc(2);
        chk("s2_vec1", 32'(int_vec), 32'h3F4);
        chk("s2_ack1", 32'(irq_ack), 32'h2);
        cyc();
        ret_pulse(); cyc();
        chk("s2_take3", 32'(int_take), 32'h1);
        chk("s2_vec3", 32'(int_vec), 32'h3FC);
        cyc();
        irq = 4'b1011; cyc();
        chk("s3_pend0", 32'(pend), 32'h1);
        chk("s3_nonest", 32'(int_take), 32'h0);
        cyc(2);
        chk("s3_nonest2", 32'(int_take), 32'h0);
        ret_pulse(); cyc();
        chk("s3_take0", 32'(int_take), 32'h1);
        chk("s3_vec0", 32'(int_vec), 32'h3F0);
        cyc(); ret_pulse();
        irq = 4'd0; cyc();

        // take_ok held low while a request is eligible
        take_ok = 1'b0; irq = 4'b0100; cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s4_blocked", 32'(int_take), 32'h0);
        end
        take_ok = 1'b1; cyc();
        chk("s4_take", 32'(int_take), 32'h1);
        cyc(); ret_pulse();
        irq = 4'd0; cyc();

        // Masked request held pending until enabled
        ie_we = 1'b1; ie_wd = 4'd0; cyc(); ie_we = 1'b0;
        irq = 4'b1000; cyc(4);
        chk("s5_pend_held", 32'(pend), 32'h8);
        chk("s5_masked", 32'(int_take), 32'h0);
        ie_we = 1'b1; ie_wd = 4'b1000; cyc(); ie_we = 1'b0;
        chk("s5_not_yet", 32'(int_take), 32'h0);
        cyc();
        chk("s5_take", 32'(int_take), 32'h1);
        chk("s5_vec", 32'(int_vec), 32'h3FC);
        cyc(); ret_pulse();
        irq = 4'd0; cyc();

        // Reset while in TAKE, line held high through reset
        ie_we = 1'b1; ie_wd = 4'hF; cyc(); ie_we = 1'b0;
        irq = 4'b0010; cyc(2);
        chk("s6_in_take", 32'(int_take), 32'h1);
        reset = 1'b1; cyc();
        chk("s6_isr", 32'(in_isr), 32'h0);
        chk("s6_pend", 32'(pend), 32'h0);
        chk("s6_take", 32'(int_take), 32'h0);
        chk("s6_ack", 32'(irq_ack), 32'h0);
        reset = 1'b0; cyc();
        chk("s6_edge_after_rst", 32'(pend), 32'h2);
        cyc(2);
        chk("s6_masked_after_rst", 32'(int_take), 32'h0);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            ie_we   = ($urandom_range(0, 15) == 0);
            ie_wd   = 4'($urandom_range(0, 15));
            take_ok = ($urandom_range(0, 3) != 0);
            reti    = ($urandom_range(0, 4) == 0);
            reset   = ($urandom_range(0, 499) == 0);
            cyc();
        end
        reset = 1'b0; reti = 1'b0; ie_we = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
